// File: rtl/visu_mon_grid_if.sv
// Bundle of the LED write port and the VGA output pins of the debug-LED grid.
// The slave modport is the grid; the master modport is whoever drives LED state.
interface visu_mon_grid_if #(
    parameter int IDX_W = 6
);
    logic             i_wr;
    logic [IDX_W-1:0] i_ledNo;
    logic             i_status;
    logic             i_blink;
    logic [11:0]      i_color;
    logic             i_clrAll;
    logic             o_hsync;
    logic             o_vsync;
    logic [3:0]       o_red;
    logic [3:0]       o_green;
    logic [3:0]       o_blue;
    logic             o_frameStart;

    modport slave (
        input  i_wr, i_ledNo, i_status, i_blink, i_color, i_clrAll,
        output o_hsync, o_vsync, o_red, o_green, o_blue, o_frameStart
    );

    modport master (
        output i_wr, i_ledNo, i_status, i_blink, i_color, i_clrAll,
        input  o_hsync, o_vsync, o_red, o_green, o_blue, o_frameStart
    );
endinterface

// File: rtl/visu_mon_grid.sv
// Debug-LED grid overlay for VGA: own 640x480 timing, LEDS_X x LEDS_Y cells with
// per-LED colour/status/blink written through a strobe port; all pins registered.
module visu_mon_grid #(
    parameter int          LEDS_X       = 8,
    parameter int          LEDS_Y       = 8,
    parameter int          LED_W        = 64,
    parameter int          LED_H        = 50,
    parameter int          GAP_X        = 10,
    parameter int          GAP_Y        = 10,
    parameter int          ORG_X        = 10,
    parameter int          ORG_Y        = 10,
    parameter int          H_ACT        = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYN        = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACT        = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYN        = 2,
    parameter int          V_BP         = 33,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] BG_COLOR     = 12'h822,
    parameter logic [11:0] OFF_COLOR    = 12'h211
) (
    input  logic             i_clkVideo,
    input  logic             i_reset,
    visu_mon_grid_if.slave   bus
);
    localparam int N     = LEDS_X * LEDS_Y;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int XW    = $clog2(LED_W + GAP_X + 1);
    localparam int YW    = $clog2(LED_H + GAP_Y + 1);
    localparam int CW    = $clog2(LEDS_X + 1);
    localparam int RW    = $clog2(LEDS_Y + 1);
    localparam int FW    = $clog2(BLINK_FRAMES) + 1;

    localparam logic [HW-1:0]  H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0]  H_ACTC = HW'(H_ACT);
    localparam logic [HW-1:0]  H_SS   = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0]  H_SE   = HW'(H_ACT + H_FP + H_SYN);
    localparam logic [HW-1:0]  H_ORG  = HW'(ORG_X);
    localparam logic [VW-1:0]  V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0]  V_ACTC = VW'(V_ACT);
    localparam logic [VW-1:0]  V_SS   = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0]  V_SE   = VW'(V_ACT + V_FP + V_SYN);
    localparam logic [VW-1:0]  V_ORG  = VW'(ORG_Y);
    localparam logic [XW-1:0]  X_LAST = XW'(LED_W + GAP_X - 1);
    localparam logic [XW-1:0]  X_LIT  = XW'(LED_W);
    localparam logic [YW-1:0]  Y_LAST = YW'(LED_H + GAP_Y - 1);
    localparam logic [YW-1:0]  Y_LIT  = YW'(LED_H);
    localparam logic [CW-1:0]  C_END  = CW'(LEDS_X);
    localparam logic [RW-1:0]  R_END  = RW'(LEDS_Y);
    localparam logic [FW-1:0]  F_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [IDX_W:0] N_C    = (IDX_W + 1)'(N);

    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic [XW-1:0] xoff_q, xoff_d;
    logic [YW-1:0] yoff_q, yoff_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
    logic [11:0]   rgb_q, rgb_d;

    logic          status_q [N];
    logic          status_d [N];
    logic          blink_q  [N];
    logic          blink_d  [N];
    logic [11:0]   color_q  [N];
    logic [11:0]   color_d  [N];

    logic             active, incell;
    logic [IDX_W-1:0] pix_idx, wr_idx;

    assign wr_idx           = bus.i_ledNo;
    assign bus.o_hsync      = hsync_q;
    assign bus.o_vsync      = vsync_q;
    assign bus.o_red        = rgb_q[11:8];
    assign bus.o_green      = rgb_q[7:4];
    assign bus.o_blue       = rgb_q[3:0];
    assign bus.o_frameStart = fs_q;

    // Raster counters and the divider-free cell trackers that follow them.
    always_comb begin
        hpos_d  = hpos_q + 1'b1;
        vpos_d  = vpos_q;
        col_d   = col_q;
        xoff_d  = xoff_q;
        row_d   = row_q;
        yoff_d  = yoff_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (hpos_q == H_LAST) begin
            hpos_d = '0;
            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
            if (vpos_d == V_ORG) begin
                row_d  = '0;
                yoff_d = '0;
            end else if (yoff_q == Y_LAST) begin
                yoff_d = '0;
                if (row_q != R_END) row_d = row_q + 1'b1;
            end else begin
                yoff_d = yoff_q + 1'b1;
            end
            if (vpos_q == V_LAST) begin
                // Phase only moves between frames so a blinking cell never tears.
                if (frame_q == F_LAST) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end
        end
        if (hpos_d == H_ORG) begin
            col_d  = '0;
            xoff_d = '0;
        end else if (xoff_q == X_LAST) begin
            xoff_d = '0;
            if (col_q != C_END) col_d = col_q + 1'b1;
        end else begin
            xoff_d = xoff_q + 1'b1;
        end
    end

    // Pixel decode from the current counters; the result lands on the pins next cycle.
    always_comb begin
        active  = (hpos_q < H_ACTC) && (vpos_q < V_ACTC);
        incell  = (hpos_q >= H_ORG) && (vpos_q >= V_ORG) && (col_q < C_END) &&
                  (row_q < R_END) && (xoff_q < X_LIT) && (yoff_q < Y_LIT);
        pix_idx = IDX_W'(int'(row_q) * LEDS_X + int'(col_q));
        rgb_d   = '0;
        if (active) begin
            if (!incell)                              rgb_d = BG_COLOR;
            else if (!status_q[pix_idx])              rgb_d = OFF_COLOR;
            else if (blink_q[pix_idx] && !phase_q)    rgb_d = OFF_COLOR;
            else                                      rgb_d = color_q[pix_idx];
        end
        hsync_d = !((hpos_q >= H_SS) && (hpos_q < H_SE));
        vsync_d = !((vpos_q >= V_SS) && (vpos_q < V_SE));
        fs_d    = (hpos_q == '0) && (vpos_q == '0);
    end

    // Clear-all is applied first so a write in the same cycle survives it.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            status_d[i] = bus.i_clrAll ? 1'b0 : status_q[i];
            blink_d[i]  = blink_q[i];
            color_d[i]  = color_q[i];
        end
        if (bus.i_wr && ({1'b0, wr_idx} < N_C)) begin
            status_d[wr_idx] = bus.i_status;
            blink_d[wr_idx]  = bus.i_blink;
            color_d[wr_idx]  = bus.i_color;
        end
    end

    always_ff @(posedge i_clkVideo or posedge i_reset) begin
        if (i_reset) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            xoff_q  <= '0;
            yoff_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
            rgb_q   <= '0;
            for (int i = 0; i < N; i++) begin
                status_q[i] <= 1'b0;
                blink_q[i]  <= 1'b0;
                color_q[i]  <= '0;
            end
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            xoff_q  <= xoff_d;
            yoff_q  <= yoff_d;
            col_q   <= col_d;
            row_q   <= row_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            rgb_q   <= rgb_d;
            for (int i = 0; i < N; i++) begin
                status_q[i] <= status_d[i];
                blink_q[i]  <= blink_d[i];
                color_q[i]  <= color_d[i];
            end
        end
    end
endmodule

// File: tb/tb_visu_mon_grid.sv
// Directed bench for visu_mon_grid on a shrunken raster (54x27 clocks, 3x2 LEDs)
// so several frames and blink periods fit in a short run.
module tb_visu_mon_grid;
    localparam int HT    = 54;
    localparam int VT    = 27;
    localparam int FRAME = HT * VT;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    logic [11:0] rgb;

    visu_mon_grid_if #(.IDX_W(3)) bus ();

    visu_mon_grid #(
        .LEDS_X(3), .LEDS_Y(2), .LED_W(8), .LED_H(5), .GAP_X(2), .GAP_Y(2),
        .ORG_X(3), .ORG_Y(2),
        .H_ACT(40), .H_FP(4), .H_SYN(6), .H_BP(4),
        .V_ACT(20), .V_FP(2), .V_SYN(2), .V_BP(3),
        .BLINK_FRAMES(2), .BG_COLOR(12'h822), .OFF_COLOR(12'h211)
    ) dut (
        .i_clkVideo(clk),
        .i_reset(rst),
        .bus(bus)
    );

    assign rgb = {bus.o_red, bus.o_green, bus.o_blue};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count since reset release: after edge k the pins show raster pixel k-1.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic seek(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((cyc - 1) % FRAME != v * HT + h) && n < FRAME + 4);
        if (n >= FRAME + 4) begin
            n_cmp++;
            n_bad++;
            $error("FAIL seek_timeout observed=%0d expected=%0d", cyc, v * HT + h);
        end
    endtask

    task automatic wr_led(input logic [2:0] idx, input logic st, input logic bl,
                          input logic [11:0] col, input logic clr);
        @(negedge clk);
        bus.i_wr     = 1'b1;
        bus.i_ledNo  = idx;
        bus.i_status = st;
        bus.i_blink  = bl;
        bus.i_color  = col;
        bus.i_clrAll = clr;
        @(negedge clk);
        bus.i_wr     = 1'b0;
        bus.i_clrAll = 1'b0;
    endtask

    initial begin
        int n;
        int f;
        logic [11:0] exp_blink;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.i_wr = 1'b0;
        bus.i_ledNo = '0;
        bus.i_status = 1'b0;
        bus.i_blink = 1'b0;
        bus.i_color = '0;
        bus.i_clrAll = 1'b0;

        // Reset state and frame-start period
        repeat (3) @(negedge clk);
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_hsync", bus.o_hsync, 1'b1);
        chk("rst_vsync", bus.o_vsync, 1'b1);
        chk("rst_fs", bus.o_frameStart, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("fs_first", bus.o_frameStart, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_frameStart && n < 2 * FRAME);
        chk("frame_len", n, FRAME);
        @(negedge clk);
        chk("fs_pulse", bus.o_frameStart, 1'b0);

        // Sync timing
        seek(43, 0);  chk("hs_before", bus.o_hsync, 1'b1);
        @(negedge clk);
        n = 0;
        while (!bus.o_hsync && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("hs_width", n, 6);
        seek(40, 0);  chk("blank_rgb", rgb, 12'h000);
        seek(53, 21); chk("vs_before", bus.o_vsync, 1'b1);
        seek(0, 22);  chk("vs_low0", bus.o_vsync, 1'b0);
        seek(53, 23); chk("vs_low1", bus.o_vsync, 1'b0);
        seek(0, 24);  chk("vs_after", bus.o_vsync, 1'b1);

        // Unwritten LED, then led0 red
        seek(3, 2);   chk("led0_off", rgb, 12'h211);
        wr_led(3'd0, 1'b1, 1'b0, 12'hF00, 1'b0);
        seek(2, 2);   chk("left_bg", rgb, 12'h822);
        seek(3, 2);   chk("led0_on", rgb, 12'hF00);
        seek(10, 6);  chk("led0_corner", rgb, 12'hF00);
        seek(11, 2);  chk("gap_x_bg", rgb, 12'h822);
        seek(3, 7);   chk("gap_y_bg", rgb, 12'h822);

        // Last LED green, neighbours
        wr_led(3'd5, 1'b1, 1'b0, 12'h0F0, 1'b0);
        seek(23, 9);  chk("led5_tl", rgb, 12'h0F0);
        seek(30, 13); chk("led5_br", rgb, 12'h0F0);
        seek(31, 9);  chk("right_bg", rgb, 12'h822);
        seek(13, 2);  chk("led1_off", rgb, 12'h211);
        seek(39, 19); chk("active_bg", rgb, 12'h822);

        // Blink: phase is 0 in frames 0,1 and toggles every 2 frames
        wr_led(3'd4, 1'b1, 1'b1, 12'h00F, 1'b0);
        for (int k = 0; k < 5; k++) begin
            seek(13, 9);
            f = (cyc - 1) / FRAME;
            exp_blink = (((f / 2) % 2) == 1) ? 12'h00F : 12'h211;
            chk("blink_top", rgb, exp_blink);
            seek(20, 13);
            chk("blink_bot", rgb, exp_blink);
        end

        // Out-of-range writes ignored; clear+write in one cycle
        wr_led(3'd6, 1'b1, 1'b0, 12'hFFF, 1'b0);
        wr_led(3'd7, 1'b1, 1'b0, 12'hFFF, 1'b0);
        seek(3, 2);   chk("oor_led0", rgb, 12'hF00);
        seek(23, 2);  chk("oor_led2", rgb, 12'h211);
        seek(3, 9);   chk("oor_led3", rgb, 12'h211);
        seek(23, 9);  chk("oor_led5", rgb, 12'h0F0);
        wr_led(3'd2, 1'b1, 1'b0, 12'h0FF, 1'b1);
        seek(3, 2);   chk("clr_led0", rgb, 12'h211);
        seek(23, 2);  chk("clr_led2", rgb, 12'h0FF);
        seek(13, 9);  chk("clr_led4", rgb, 12'h211);
        seek(23, 9);  chk("clr_led5", rgb, 12'h211);

        // Asynchronous reset mid-line
        seek(23, 2);  chk("pre_rst_rgb", rgb, 12'h0FF);
        #2 rst = 1'b1;
        #1 chk("async_rgb", rgb, 12'h000);
        chk("async_fs", bus.o_frameStart, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_fs", bus.o_frameStart, 1'b1);
        seek(23, 2);  chk("rst_cleared", rgb, 12'h211);
        seek(46, 0);  chk("pre_rst_hs", bus.o_hsync, 1'b0);
        #2 rst = 1'b1;
        #1 chk("async_hs", bus.o_hsync, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        seek(0, 22);  chk("pre_rst_vs", bus.o_vsync, 1'b0);
        #2 rst = 1'b1;
        #1 chk("async_vs", bus.o_vsync, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
